// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the MEM-stage handshake and bus signals.
//   master - the surrounding pipeline (execute, SRAM, write-back, decode side)
//   slave  - the MEM stage itself
interface mem_stage_if #(
  parameter int EXE_TO_MEM_WD = 74,
  parameter int MEM_TO_WB_WD  = 70,
  parameter int MEM_TO_ID_WD  = 39
);
  // Valid/ready semantics: a transfer happens on a rising clk edge where the
  // producer's valid and the consumer's allowin are both 1. Once mem_to_wb_valid
  // is high, mem_to_wb_bus stays stable until wb_allowin accepts it.
  logic                     mem_allowin;
  logic                     exe_to_mem_valid;
  logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus;
  logic [31:0]              data_sram_rdata;
  logic                     wb_allowin;
  logic                     mem_to_wb_valid;
  logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus;

  modport master (
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus,
    output exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata, wb_allowin
  );

  modport slave (
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus,
    input  exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata, wb_allowin
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and write-back.
// Latches the execute payload, captures synchronous SRAM read data (buffering
// it across write-back stalls), extracts sub-word loads and forwards the
// result to write-back and to decode for bypassing.
// Optional feature macro: MEM_LOAD_EXT_EN enables ld.b/ld.h/ld.bu/ld.hu
// extraction; without it every load returns the full SRAM word.
module mem_stage #(
  parameter int EXE_TO_MEM_WD = 74,
  parameter int MEM_TO_WB_WD  = 70,
  parameter int MEM_TO_ID_WD  = 39
) (
  input  logic          clk,
  input  logic          resetn,
  mem_stage_if.slave    io
);

  localparam logic MEM_READY_GO = 1'b1;

  // Registered state
  logic                     mem_valid_q, mem_valid_d;
  logic                     first_q, first_d;
  logic                     buf_vld_q, buf_vld_d;
  logic [EXE_TO_MEM_WD-1:0] payload_q, payload_d;
  logic [31:0]              rdata_buf_q, rdata_buf_d;

  // Handshake and payload fields
  logic        allowin;
  logic        accept;
  logic        leave;
  logic [2:0]  ld_op;
  logic        reg_w;
  logic [4:0]  reg_w_addr;
  logic        res_from_mem;
  logic [31:0] exe_result;
  logic [31:0] pc;
  logic [31:0] raw_rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ld_op        = payload_q[73:71];
  assign reg_w        = payload_q[70];
  assign reg_w_addr   = payload_q[69:65];
  assign res_from_mem = payload_q[64];
  assign exe_result   = payload_q[63:32];
  assign pc           = payload_q[31:0];

  assign allowin = ~mem_valid_q | (MEM_READY_GO & io.wb_allowin);
  assign accept  = allowin & io.exe_to_mem_valid;
  assign leave   = mem_valid_q & MEM_READY_GO & io.wb_allowin;

  // Next-state: valid bit, payload, first-cycle flag and the stall buffer
  always_comb begin
    mem_valid_d = mem_valid_q;
    payload_d   = payload_q;
    first_d     = accept;
    buf_vld_d   = buf_vld_q;
    rdata_buf_d = rdata_buf_q;
    if (allowin) begin
      mem_valid_d = io.exe_to_mem_valid;
    end
    if (accept) begin
      payload_d = io.exe_to_mem_bus;
    end
    // SRAM data is only present in the first cycle; keep a copy if WB stalls.
    // A stall means neither leave nor accept can happen this cycle.
    if (first_q && mem_valid_q && !io.wb_allowin) begin
      rdata_buf_d = io.data_sram_rdata;
      buf_vld_d   = 1'b1;
    end else if (leave || accept) begin
      buf_vld_d   = 1'b0;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      first_q     <= 1'b0;
      buf_vld_q   <= 1'b0;
      payload_q   <= '0;
      rdata_buf_q <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      first_q     <= first_d;
      buf_vld_q   <= buf_vld_d;
      payload_q   <= payload_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // Pick live SRAM data on the first cycle, the held copy afterwards
  always_comb begin
    raw_rdata = io.data_sram_rdata;
    if (!first_q && buf_vld_q) begin
      raw_rdata = rdata_buf_q;
    end
  end

`ifdef MEM_LOAD_EXT_EN
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign off     = exe_result[1:0];
  assign ld_byte = raw_rdata[8*off +: 8];
  // off[0] is ignored for halfwords; misalignment is trapped upstream
  assign ld_half = off[1] ? raw_rdata[31:16] : raw_rdata[15:0];

  // Sub-word extraction and sign/zero extension
  always_comb begin
    load_data = raw_rdata;
    case (ld_op)
      3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b011:  load_data = {24'b0, ld_byte};
      3'b100:  load_data = {16'b0, ld_half};
      default: load_data = raw_rdata;
    endcase
  end
`else
  // ld_op stays in the bus layout but has no effect in this build
  logic unused_ld_op;
  assign unused_ld_op = ^ld_op;
  assign load_data    = raw_rdata;
`endif

  assign final_result = res_from_mem ? load_data : exe_result;

  assign io.mem_allowin     = allowin;
  assign io.mem_to_wb_valid = mem_valid_q & MEM_READY_GO;
  assign io.mem_to_wb_bus   = {reg_w, reg_w_addr, final_result, pc};
  assign io.mem_to_id_bus   = {mem_valid_q, reg_w, reg_w_addr, final_result};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, sitting between the execute stage and write-back. It latches execute results under the valid/allowin handshake and captures synchronous data-SRAM read data, holding it across write-back stalls. It extracts and extends sub-word loads, then forwards the final result to write-back and the RAW-bypass view to decode.

## Interface
Parameters:
- EXE_TO_MEM_WD, 74, width of {ld_op[2:0], regW, regWAddr[4:0], res_from_mem, exe_result[31:0], pc[31:0]} (MSB first)
- MEM_TO_WB_WD, 70, width of {regW, regWAddr[4:0], final_result[31:0], pc[31:0]}
- MEM_TO_ID_WD, 39, width of {mem_valid, regW, regWAddr[4:0], final_result[31:0]}

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- mem_allowin  out  1  stage can accept an instruction this cycle
- exe_to_mem_valid  in  1  execute offers an instruction
- exe_to_mem_bus  in  EXE_TO_MEM_WD  execute payload
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the request issued in execute
- wb_allowin  in  1  write-back can accept
- mem_to_wb_valid  out  1  instruction offered to write-back
- mem_to_wb_bus  out  MEM_TO_WB_WD  write-back payload
- mem_to_id_bus  out  MEM_TO_ID_WD  bypass/hazard info for decode

## Operation
- Handshake: mem_ready_go = 1. mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin). mem_to_wb_valid = mem_valid & mem_ready_go.
- On mem_allowin: mem_valid <= exe_to_mem_valid. On mem_allowin & exe_to_mem_valid: the payload register loads exe_to_mem_bus.
- Read-data capture:
  - first flag sets the cycle after a new instruction is latched, and clears otherwise.
  - When first=1, raw_rdata = data_sram_rdata.
  - When first=1 and mem_valid & ~wb_allowin: rdata_buf <= data_sram_rdata and buf_vld <= 1.
  - When first=0 and buf_vld=1, raw_rdata = rdata_buf.
  - buf_vld clears when the instruction leaves (mem_to_wb_valid & wb_allowin) or a new one is latched.
- Load extraction uses off = exe_result[1:0] and the ld_op encoding 000 ld.w, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu. Other codes behave as ld.w.
  - Byte loads select raw_rdata[8*off+7 : 8*off].
  - Halfword loads select raw_rdata[16*off[1]+15 : 16*off[1]]. off[0] is ignored; alignment faults are handled elsewhere.
  - Word loads ignore off.
  - .b and .h sign-extend; .bu and .hu zero-extend.
- final_result = res_from_mem ? load_data : exe_result.
- mem_to_wb_bus = {regW, regWAddr, final_result, pc}.
- mem_to_id_bus = {mem_valid, regW, regWAddr, final_result}. Load data is available here, so decode need not stall on a MEM-stage load.

## Timing
- Reset values:
  - mem_valid = 0, first = 0, buf_vld = 0.
  - The payload register and rdata_buf clear to 0.
  - As a result, mem_allowin = 1, mem_to_wb_valid = 0, mem_to_id_bus[38] = 0, and all bus data fields are 0.
- Latency: 1 cycle from EXE acceptance to mem_to_wb_valid. final_result is combinational from registered state and SRAM data in that cycle.
- Stall: while wb_allowin = 0, mem_to_wb_bus stays stable, using rdata_buf even though the SRAM output changes.
- Back-to-back: if an instruction leaves and a new one is latched in the same cycle, the new instruction sets first = 1 and buf_vld clears.
- Bubble: if mem_valid = 0, outputs are don't-care except the valid bits. No rdata capture occurs.
- Reset mid-stall discards the held instruction and buffer.

## Configuration
- MEM_LOAD_EXT_EN defined: sub-word extraction and extension as above.
- MEM_LOAD_EXT_EN undefined:
  - ld_op is ignored, and load_data = raw_rdata for every load.
  - The ld_op bus bits remain in the port but are unused.

## Test plan
- Reset then idle: mem_allowin = 1, mem_to_wb_valid = 0, mem_to_id_bus = 0.
- ld.b at offset 3 with rdata 0x80FF_1234, wb_allowin = 1: final_result = 0xFFFF_FF80 one cycle after acceptance. The same access as ld.bu gives 0x0000_0080.
- ld.h at offset 2 with rdata 0x8001_7FFF gives 0xFFFF_8001. ld.hu at offset 0 gives 0x0000_7FFF.
- Load with rdata 0x1234_5678, then wb_allowin = 0 for 3 cycles while SRAM rdata changes to 0xDEAD_BEEF: the bus holds 0x1234_5678 and mem_allowin = 0 throughout. It is delivered on the release cycle.
- Non-load (res_from_mem = 0, exe_result = 0x0000_0042) followed back-to-back by a load: consecutive cycles show 0x42, then the load data. mem_to_id_bus tracks each instruction.
- Built without MEM_LOAD_EXT_EN, ld.b at offset 1 with rdata 0xAABB_CCDD returns 0xAABB_CCDD.
